// File: rtl/ht_loader.sv
// Frame loader for a sort network: collects up to `index` elements, pads short
// frames, pulses `start`, then holds off for `gap` cycles before refilling.
//
// state | meaning
// FILL  | accepting beats into slot wr_ptr
// LOAD  | frame complete, start pulse this cycle
// HOLD  | settle time for the sort network, counter runs down to 0
module ht_loader #(
  parameter int index = 32,
  parameter int width = 5,
  parameter int gap   = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [width-1:0]             in_data,
  input  logic                         in_last,
  output logic                         in_ready,
  input  logic                         flush,
  output logic                         start,
  output logic [width-1:0]             indata [0:index-1],
  output logic [$clog2(index+1)-1:0]   frame_len,
  output logic                         busy
);

  localparam int PW = (index > 1) ? $clog2(index) : 1;
  localparam int LW = $clog2(index + 1);
  localparam int CW = (gap > 1) ? $clog2(gap) : 1;
  localparam logic [PW-1:0]    LAST_SLOT = PW'(index - 1);
  localparam logic [width-1:0] PAD       = '1;

  typedef enum logic [1:0] {FILL, LOAD, HOLD} state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [LW-1:0]       len_q, len_d;
  logic [width-1:0]    slots_q [0:index-1];
  logic [width-1:0]    slots_d [0:index-1];
  logic                rdy_en_q;
  logic                accept;

  // Keeps in_ready low while reset is held and for the release cycle.
  assign in_ready  = rdy_en_q && (state_q == FILL);
  assign accept    = in_valid && in_ready;
  assign start     = (state_q == LOAD);
  assign busy      = (state_q == LOAD) || (state_q == HOLD);
  assign frame_len = len_q;
  assign indata    = slots_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= FILL;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      rdy_en_q <= 1'b0;
      for (int i = 0; i < index; i++) slots_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      rdy_en_q <= 1'b1;
      slots_q  <= slots_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    slots_d  = slots_q;
    case (state_q)
      FILL: begin
        if (flush) begin
          wr_ptr_d = '0;
        end else if (accept) begin
          slots_d[wr_ptr_q] = in_data;
          if (in_last || (wr_ptr_q == LAST_SLOT)) begin
            // Pad everything above the final real element in the same edge.
            for (int i = 0; i < index; i++) begin
              if (i > int'(wr_ptr_q)) slots_d[i] = PAD;
            end
            len_d   = LW'(wr_ptr_q) + LW'(1);
            state_d = LOAD;
          end else begin
            wr_ptr_d = wr_ptr_q + PW'(1);
          end
        end
      end
      LOAD: begin
        cnt_d   = CW'(gap - 1);
        state_d = HOLD;
      end
      HOLD: begin
        if (cnt_q == '0) begin
          wr_ptr_d = '0;
          state_d  = FILL;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = FILL;
    endcase
  end

endmodule

// File: doc/ht_loader.md
HT_LOADER -- requirements
Module: ht_loader

Interface
REQ-001 Parameter: index, default 32, number of elements per frame.
REQ-002 Parameter: width, default 5, bits per element.
REQ-003 Parameter: gap, default 6, HOLD cycles after each start pulse (legal range >= 1).
REQ-004 Port: clk  input  1  single clock; all flops on rising edge.
REQ-005 Port: rst  input  1  reset, asynchronous assert, active-low; released synchronously to clk by the system.
REQ-006 Port: in_valid  input  1  upstream element valid.
REQ-007 Port: in_data  input  width  upstream element value.
REQ-008 Port: in_last  input  1  qualifies the current beat as the final element of a short frame.
REQ-009 Port: in_ready  output  1  loader accepts in_data this cycle.
REQ-010 Port: flush  input  1  synchronous abort of the partial frame.
REQ-011 Port: start  output  1  one-cycle pulse; drives the downstream sort network's start input.
REQ-012 Port: indata  output  width x index unpacked array [0:index-1]  frame presented to the sort network.
REQ-013 Port: frame_len  output  $clog2(index+1)  count of real (non-pad) elements in the last launched frame.
REQ-014 Port: busy  output  1  high in LOAD and HOLD.

Function
REQ-015 FSM states SHALL be FILL, LOAD, HOLD; reset state FILL.
REQ-016 FILL: in_ready=1; a beat is accepted when in_valid & in_ready, written to slot wr_ptr, then wr_ptr increments.
REQ-017 FILL -> LOAD when the beat in slot index-1 is accepted, or when an accepted beat has in_last=1.
REQ-018 On in_last at slot k < index-1: slots k+1..index-1 SHALL be written with pad value {width{1'b1}} on the same clock edge.
REQ-019 frame_len SHALL update on the edge entering LOAD to k+1 (index for a full frame).
REQ-020 LOAD: start=1 for exactly one cycle, in_ready=0; LOAD -> HOLD unconditionally; gap counter loaded with gap-1.
REQ-021 HOLD: in_ready=0; counter decrements each cycle; at 0, HOLD -> FILL with wr_ptr cleared to 0.
REQ-022 Latency: last beat accepted at cycle N -> start=1 at cycle N+1 -> in_ready=1 again at cycle N+2+gap.
REQ-023 indata SHALL be stable and valid in the start cycle; it is undefined-by-contract (but not X) during the next FILL.
REQ-024 in_valid while in_ready=0 SHALL be ignored; the upstream holds data (valid/ready rule).
REQ-025 flush in FILL: wr_ptr cleared, no start; a beat accepted in the same cycle is discarded (flush wins).
REQ-026 flush in LOAD or HOLD SHALL be ignored; the launched frame completes.
REQ-027 in_last on a slot index-1 beat SHALL be treated as a full frame (frame_len = index, no pad).

Reset
REQ-028 While rst=0: state FILL, wr_ptr 0, counter 0, start 0, in_ready 0, busy 0, frame_len 0, all indata slots 0.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame; after release the first accepted beat lands in slot 0.
REQ-030 in_ready SHALL rise on the first clk edge after rst deasserts.

Verification
REQ-031 32 back-to-back beats, values 0..31 -> in_ready high all 32 cycles, start one cycle after beat 31, indata[i]=i, frame_len=32.
REQ-032 Beats 3,1,4,1,5 with in_last on the 5th -> start next cycle, indata[0..4]=3,1,4,1,5, indata[5..31]=31, frame_len=5.
REQ-033 in_valid toggled every other cycle over 32 beats -> only valid beats stored, order preserved, exactly one start.
REQ-034 flush after 10 beats, then 32 beats of 7 -> no start from the partial frame, all slots 7, frame_len=32.
REQ-035 rst low at beat 20 -> outputs zero asynchronously; after release, a new 32-beat frame fills slots from 0.
REQ-036 Two full frames back-to-back, gap=6 -> in_ready low exactly 7 cycles between frames, two starts 39 cycles apart.
